// File: rtl/std_gray_sync_decoder.sv
// Gray-coded pointer receiver: multi-flop synchronizer, Gray-to-binary decode and increment report.
// Define STD_GRAY_SYNC_CHECK_EN to add a sticky flag for multi-bit Gray transitions.
module std_gray_sync_decoder #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_gray,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_bin,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_delta,
  output logic             o_err
);

  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W  = $clog2(STAGES + 2);
  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(STAGES + 1);

  logic [WIDTH-1:0] sync [STAGES];
  logic [WIDTH-1:0] decode;
  logic [CNT_W-1:0] fill_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STAGES; i++) sync[i] <= '0;
    end else begin
      sync[0] <= i_gray;
      for (int i = 1; i < STAGES; i++) sync[i] <= sync[i-1];
    end
  end

  // Suffix-XOR scan: each level doubles the span folded into every bit.
  always_comb begin
    decode = sync[STAGES-1];
    for (int l = 0; l < LEVELS; l++) decode = decode ^ (decode >> (1 << l));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_bin    <= '0;
      o_delta  <= '0;
      fill_cnt <= '0;
    end else begin
      o_bin   <= decode;
      o_delta <= i_clear ? '0 : decode - o_bin;
      if (fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + CNT_W'(1);
    end
  end

  assign o_valid = (fill_cnt == FILL_MAX);

`ifdef STD_GRAY_SYNC_CHECK_EN
  logic [WIDTH-1:0] prev_sync;
  logic [WIDTH-1:0] flip;
  logic             multi_flip;

  // Clearing the lowest set bit leaves something only if two or more bits toggled.
  assign flip       = sync[STAGES-1] ^ prev_sync;
  assign multi_flip = |(flip & (flip - WIDTH'(1)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_sync <= '0;
      o_err     <= 1'b0;
    end else begin
      prev_sync <= sync[STAGES-1];
      if (multi_flip)   o_err <= 1'b1;
      else if (i_clear) o_err <= 1'b0;
    end
  end
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: doc/std_gray_sync_decoder.md
# std_gray_sync_decoder

Receive-side stage for Gray-coded pointers and counters that cross into this clock domain. It runs a Gray input through a multi-flop synchronizer, decodes it to binary, and registers the result. It also reports the per-sample increment and, optionally, flags multi-bit Gray transitions. It sits directly downstream of a Gray-encoding pointer in the source domain and feeds binary pointer consumers, such as FIFO level and full/empty logic, in the destination domain.

## Interface
Parameters:
- WIDTH, 4, Gray/binary vector width; legal ≥ 1.
- STAGES, 2, synchronizer flop count; legal ≥ 2.

Ports:
- i_clk  input  1  destination-domain clock; all state on rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_gray  input  WIDTH  Gray-coded value from the source domain; asynchronous to i_clk.
- i_clear  input  1  synchronous clear of o_delta and o_err.
- o_bin  output  WIDTH  registered binary decode of the synchronized Gray value.
- o_valid  output  1  high once the pipeline holds post-reset samples.
- o_delta  output  WIDTH  (new o_bin − previous o_bin) mod 2^WIDTH.
- o_err  output  1  sticky multi-bit-transition flag (see Configuration).

## Operation
- Synchronizer: STAGES-deep flop chain sync[0..STAGES-1] on i_gray. sync[0] samples i_gray; no logic between flops. All flops reset to 0.
- Decode: combinational Gray→binary decode of sync[STAGES-1], defined as bin[k] = ^gray[WIDTH-1:k]. O(log WIDTH) depth.
- Output register: o_bin loads the decode every cycle. Reset value is 0.
- Delta: o_delta loads decode − o_bin (current register value), mod 2^WIDTH, on the same edge as o_bin. Reset value is 0.
- Fill counter: counts edges after reset release, saturating at STAGES+1. o_valid = (count == STAGES+1). Reset value is 0.
- i_clear: on the next edge, o_delta is forced to 0 and o_err is cleared. o_bin and the synchronizer are unaffected.
- Simultaneous events:
  - Error detection and i_clear on the same edge: o_err ends at 1 (set wins).
  - i_clear and a new delta on the same edge: o_delta ends at 0.
- Wrap-around: Gray 1000 → 0000 (WIDTH=4) decodes binary 15 → 0, giving o_delta = 1. The mod-2^WIDTH arithmetic has no special case.
- Reset mid-operation: asynchronous assertion zeroes all flops, o_bin, o_delta, o_err and o_valid immediately. The fill count restarts on release.

## Timing
- Latency: a change of i_gray that meets setup before edge N is visible on o_bin after edge N+STAGES, i.e. STAGES+1 edges end to end. This gives 3 edges at STAGES=2.
- o_delta and o_err update on the same edge as o_bin.
- o_valid rises on the (STAGES+1)th rising edge after i_rst_n deasserts.
- No handshake. A new sample is produced every cycle, and the consumer qualifies it with o_valid.
- Throughput is 1 sample/cycle. The input must change at most one bit per source update to be correctly captured.

## Configuration
- STD_GRAY_SYNC_CHECK_EN defined:
  - A checker compares sync[STAGES-1] with its previous value (an extra WIDTH-bit register, reset 0).
  - If more than one bit differs, o_err sets on the edge o_bin loads the offending decode. It stays set until i_clear or reset.
  - With WIDTH=1 the checker can never fire.
- STD_GRAY_SYNC_CHECK_EN undefined: checker logic and its register are absent, and o_err is tied 0.

## Test plan
- Reset: hold i_rst_n=0 with i_gray=1010 → o_bin=0, o_delta=0, o_err=0, o_valid=0. Release and count edges → o_valid=1 on edge 3 (STAGES=2).
- Latency: WIDTH=4, STAGES=2, i_gray 0000 → 0001 before edge N → o_bin=1 and o_delta=1 after edge N+2, o_bin=0 after edge N+1.
- Count and wrap: drive the Gray sequence for binary 0..15 and then back to 0, one step every 4 cycles → o_bin tracks 0..15, 0. o_delta=1 on each update, including the 15→0 wrap. o_err stays 0.
- Multi-bit error (macro defined): i_gray 0000 → 0011 → o_bin=2, o_delta=2, o_err=1 on the same edge. o_err holds for 10 further cycles. Pulse i_clear → o_err=0 and o_delta=0 on the next edge. i_clear coincident with a second violation → o_err=1.
- Macro undefined: the same 0000 → 0011 stimulus gives o_bin=2, o_delta=2, o_err=0.
- Mid-operation reset: assert i_rst_n=0 asynchronously while o_bin=9 → all outputs read 0 before the next edge. After release, o_valid returns only after STAGES+1 edges.
